gemm_addr_sched: RTL and testbench
==================================

# gemm_addr_sched

Read-address scheduler for the engine's data and weight BRAM buffers (the `d_fifo`/`w_fifo` banks loaded from the host pipes).
- Once per layer, from the latched command fields, walks every output pixel's convolution window.
- Issues one data/weight read-address pair per cycle.
- Emits a validity strobe aligned to BRAM read data, with window-boundary markers for the engine's accumulator.
- Takes address sequencing out of the engine state machine; the engine only consumes aligned operands.

## Interface
Parameters:
- `ADDR_W`, 13, BRAM address width (8192-deep buffers).
- `BRAM_LAT`, 1, BRAM read latency in cycles (address to `doutb`); legal range 1-3.

Ports:
- `clk` in 1, system clock (`sys_clk` domain).
- `rst_n` in 1, synchronous active-low reset.
- `start` in 1, single-cycle pulse; latches configuration and begins a layer.
- `kernel` in 8, kernel side length K.
- `stride` in 4, stride S.
- `i_side` in 8, input feature-map side length.
- `o_side` in 8, output feature-map side length.
- `i_channel` in 16, input channel count C.
- `d_base` in ADDR_W, data buffer base address.
- `w_base` in ADDR_W, weight buffer base address.
- `stall` in 1, engine back-pressure; blocks issue of new addresses.
- `d_fifo_read_addr` out ADDR_W, data BRAM read address.
- `w_fifo_read_addr` out ADDR_W, weight BRAM read address.
- `rd_valid` out 1, BRAM read data valid this cycle.
- `win_first` out 1, first operand of a window; aligned with `rd_valid`.
- `win_last` out 1, last operand of a window; aligned with `rd_valid`.
- `busy` out 1, layer in progress.
- `done` out 1, single-cycle pulse when the layer completes.
- `pad` in 4, zero-padding width P (`GEMM_PAD_EN` only).
- `pad_zero` out 1, current operand is padding; aligned with `rd_valid` (`GEMM_PAD_EN` only).

## Operation
- States:
  - IDLE: `start` → RUN, or → DONE if K, C or `o_side` is 0.
  - RUN: last address issued → DRAIN.
  - DRAIN: waits BRAM_LAT cycles → DONE.
  - DONE: one cycle → IDLE.
- `start` outside IDLE is ignored. Config inputs are sampled only on the accepted `start` cycle.
- Loop order, innermost first: c in [0,C), kx in [0,K), ky in [0,K), ox in [0,o_side), oy in [0,o_side).
- Input coordinates: iy = oy·S + ky − P, ix = ox·S + kx − P (P = 0 without `GEMM_PAD_EN`).
- Data address = d_base + (iy·i_side + ix)·C + c.
- Weight address = w_base + (ky·K + kx)·C + c.
- Both addresses are truncated modulo 2^ADDR_W (wrap-around, no error flag).
- Window length is K·K·C operands.
  - `win_first` marks c=kx=ky=0.
  - `win_last` marks c=C−1, kx=ky=K−1.
  - For K=C=1, both marks are high on the same operand.
- One address pair is issued per RUN cycle with `stall`=0. During `stall`=1, addresses hold and no issue occurs. Already-issued reads still emerge with `rd_valid` (the engine must absorb them).
- `busy` is high in RUN and DRAIN. `done` is high only in DONE.
- `rst_n`=0 on any cycle, including mid-layer, has these effects on the next edge:
  - State goes to IDLE and all counters clear.
  - In-flight `rd_valid`, `win_first` and `win_last` are discarded (no emission).

## Timing
- Reset values: both addresses 0; `rd_valid`, `win_first`, `win_last`, `busy`, `done`, `pad_zero` all 0.
- `start` at edge t:
  - `busy`=1 and the first address is driven after edge t+1.
  - Matching `rd_valid` is high BRAM_LAT cycles later.
- The valid, window-marker and pad-flag pipeline is exactly BRAM_LAT registers deep. It is not affected by `stall`.
- Unstalled throughput is 1 operand per cycle.
- `done` asserts on the cycle after the final `rd_valid` and lasts 1 cycle.
- Total unstalled layer time from `start` to `done` = o_side²·K²·C + BRAM_LAT + 2 cycles.
- Degenerate config (K, C or `o_side` = 0): `done` one cycle after `start`, with no `rd_valid`.

## Configuration
- `GEMM_PAD_EN` defined:
  - `pad` input and `pad_zero` output exist.
  - An operand with iy or ix outside [0, i_side) is still issued and counted, with `d_fifo_read_addr` = d_base.
  - Its `pad_zero`=1; the engine substitutes zero for the data operand. Weight address is unaffected.
- `GEMM_PAD_EN` undefined:
  - Both ports are absent and P = 0.
  - Coordinates are never negative.

## Test plan
- K=1, S=1, i_side=o_side=2, C=1, bases 0 → data addrs 0,1,2,3; weight addr 0 each time; `win_first`=`win_last`=1 on all 4 operands; `done` 1 cycle after the 4th `rd_valid`.
- K=3, S=2, i_side=5, o_side=2, C=2, bases 0 → first window data 0-5, 10-15, 20-25; second window starts at 4; weight 0-17 in every window; 72 `rd_valid` total; `win_last` on every 18th.
- Same config with `stall` high for 5 cycles mid-window → address sequence unchanged, total cycles +5, no duplicated or dropped operand.
- `d_base`=8190, K=1, C=4, o_side=i_side=1 → data addrs 8190, 8191, 0, 1 (wrap).
- C=0 → `done` one cycle after `start`, no `rd_valid`; `rst_n`=0 at operand 10 of a layer → all outputs 0 next edge; a new `start` restarts from address `d_base`.
- `GEMM_PAD_EN`, K=3, P=1, S=1, i_side=o_side=2, C=1 → window (0,0) `pad_zero` pattern 1,1,1,1,0,0,1,0,0; unpadded data addrs 0,1,2,3.

Source files
------------

// File: rtl/gemm_addr_sched.sv
// Read-address scheduler for the GEMM data/weight BRAM buffers.
// Optional zero padding is enabled with `define GEMM_PAD_EN.
module gemm_addr_sched #(
  parameter int ADDR_W   = 13,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        kernel,
  input  logic [3:0]        stride,
  input  logic [7:0]        i_side,
  input  logic [7:0]        o_side,
  input  logic [15:0]       i_channel,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic              stall,
  output logic [ADDR_W-1:0] d_fifo_read_addr,
  output logic [ADDR_W-1:0] w_fifo_read_addr,
  output logic              rd_valid,
  output logic              win_first,
  output logic              win_last,
  output logic              busy,
  output logic              done
`ifdef GEMM_PAD_EN
  ,
  input  logic [3:0]        pad,
  output logic              pad_zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_k;
  logic [3:0]        r_s;
  logic [7:0]        r_is;
  logic [7:0]        r_os;
  logic [15:0]       r_c;
  logic [ADDR_W-1:0] r_db;
  logic [ADDR_W-1:0] r_wb;

  logic [15:0] r_cc;
  logic [7:0]  r_kx;
  logic [7:0]  r_ky;
  logic [7:0]  r_ox;
  logic [7:0]  r_oy;
  logic [1:0]  r_dcnt;

  logic [BRAM_LAT-1:0] r_v;
  logic [BRAM_LAT-1:0] r_f;
  logic [BRAM_LAT-1:0] r_l;

  logic w_c_end;
  logic w_kx_end;
  logic w_ky_end;
  logic w_ox_end;
  logic w_oy_end;
  logic w_first;
  logic w_last;
  logic w_last_op;
  logic w_issue;
  logic w_degen;
  logic w_inside;

  logic [31:0]       w_p;
  logic [31:0]       w_iy;
  logic [31:0]       w_ix;
  logic [ADDR_W-1:0] w_doff;
  logic [ADDR_W-1:0] w_woff;

  assign w_c_end   = (r_cc == r_c - 16'd1);
  assign w_kx_end  = (r_kx == r_k - 8'd1);
  assign w_ky_end  = (r_ky == r_k - 8'd1);
  assign w_ox_end  = (r_ox == r_os - 8'd1);
  assign w_oy_end  = (r_oy == r_os - 8'd1);
  assign w_first   = (r_cc == '0) && (r_kx == '0)
                     && (r_ky == '0);
  assign w_last    = w_c_end && w_kx_end && w_ky_end;
  assign w_last_op = w_last && w_ox_end && w_oy_end;
  assign w_issue   = (r_state == S_RUN) && !stall;
  assign w_degen   = (kernel == '0) || (i_channel == '0)
                     || (o_side == '0);

`ifdef GEMM_PAD_EN
  logic [3:0]          r_p;
  logic [BRAM_LAT-1:0] r_z;
  assign w_p      = 32'(r_p);
  assign w_inside = (w_iy < 32'(r_is))
                    && (w_ix < 32'(r_is));
  assign pad_zero = r_z[BRAM_LAT-1];
`else
  assign w_p      = '0;
  assign w_inside = 1'b1;
`endif

  // Out-of-range coordinates go negative and compare as huge unsigned.
  assign w_iy = 32'(r_oy) * 32'(r_s) + 32'(r_ky) - w_p;
  assign w_ix = 32'(r_ox) * 32'(r_s) + 32'(r_kx) - w_p;

  assign w_doff = ADDR_W'((w_iy * 32'(r_is) + w_ix)
                  * 32'(r_c) + 32'(r_cc));
  assign w_woff = ADDR_W'((32'(r_ky) * 32'(r_k)
                  + 32'(r_kx)) * 32'(r_c) + 32'(r_cc));

  always_comb begin
    d_fifo_read_addr = '0;
    w_fifo_read_addr = '0;
    if (r_state == S_RUN) begin
      d_fifo_read_addr = w_inside ? r_db + w_doff : r_db;
      w_fifo_read_addr = r_wb + w_woff;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start) w_next = w_degen ? S_DONE : S_RUN;
      S_RUN:
        if (w_issue && w_last_op) w_next = S_DRAIN;
      S_DRAIN:
        if (r_dcnt == 2'(BRAM_LAT - 1)) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k  <= '0;
      r_s  <= '0;
      r_is <= '0;
      r_os <= '0;
      r_c  <= '0;
      r_db <= '0;
      r_wb <= '0;
`ifdef GEMM_PAD_EN
      r_p  <= '0;
`endif
    end else if (r_state == S_IDLE && start) begin
      r_k  <= kernel;
      r_s  <= stride;
      r_is <= i_side;
      r_os <= o_side;
      r_c  <= i_channel;
      r_db <= d_base;
      r_wb <= w_base;
`ifdef GEMM_PAD_EN
      r_p  <= pad;
`endif
    end
  end

  // Loop nest, innermost first: c, kx, ky, ox, oy.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == S_IDLE && start)) begin
      r_cc <= '0;
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (w_issue) begin
      if (!w_c_end) begin
        r_cc <= r_cc + 16'd1;
      end else begin
        r_cc <= '0;
        if (!w_kx_end) begin
          r_kx <= r_kx + 8'd1;
        end else begin
          r_kx <= '0;
          if (!w_ky_end) begin
            r_ky <= r_ky + 8'd1;
          end else begin
            r_ky <= '0;
            if (!w_ox_end) begin
              r_ox <= r_ox + 8'd1;
            end else begin
              r_ox <= '0;
              r_oy <= r_oy + 8'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_DRAIN) r_dcnt <= '0;
    else                              r_dcnt <= r_dcnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      r_f <= '0;
      r_l <= '0;
`ifdef GEMM_PAD_EN
      r_z <= '0;
`endif
    end else begin
      r_v[0] <= w_issue;
      r_f[0] <= w_issue && w_first;
      r_l[0] <= w_issue && w_last;
`ifdef GEMM_PAD_EN
      r_z[0] <= w_issue && !w_inside;
`endif
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_f[i] <= r_f[i-1];
        r_l[i] <= r_l[i-1];
`ifdef GEMM_PAD_EN
        r_z[i] <= r_z[i-1];
`endif
      end
    end
  end

  assign rd_valid  = r_v[BRAM_LAT-1];
  assign win_first = r_f[BRAM_LAT-1];
  assign win_last  = r_l[BRAM_LAT-1];
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_gemm_addr_sched.sv
// Directed-vector bench for gemm_addr_sched.
// Define GEMM_PAD_EN to also cover padded windows.
module tb_gemm_addr_sched;
  localparam int AW  = 13;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    kernel = '0;
  logic [3:0]    stride = '0;
  logic [7:0]    i_side = '0;
  logic [7:0]    o_side = '0;
  logic [15:0]   i_channel = '0;
  logic [AW-1:0] d_base = '0;
  logic [AW-1:0] w_base = '0;
  logic          stall = 1'b0;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] w_addr;
  logic          rd_valid;
  logic          win_first;
  logic          win_last;
  logic          busy;
  logic          done;
  logic [3:0]    pad = '0;
  logic          pad_zero;

  gemm_addr_sched #(.ADDR_W(AW), .BRAM_LAT(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .kernel(kernel),
    .stride(stride),
    .i_side(i_side),
    .o_side(o_side),
    .i_channel(i_channel),
    .d_base(d_base),
    .w_base(w_base),
    .stall(stall),
    .d_fifo_read_addr(d_addr),
    .w_fifo_read_addr(w_addr),
    .rd_valid(rd_valid),
    .win_first(win_first),
    .win_last(win_last),
    .busy(busy),
    .done(done)
`ifdef GEMM_PAD_EN
    ,
    .pad(pad),
    .pad_zero(pad_zero)
`endif
  );

`ifndef GEMM_PAD_EN
  assign pad_zero = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int k, s, is, os, c, db, wb, p;
    int st_at, st_len;
    int exp_n, exp_done, exp_last, exp_d0;
  } vec_t;

  vec_t vt[8];
  int   n_vec;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cap_d[$];
  int   cap_w[$];
  int   cap_z[$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int ed[$], ew[$], ef[$], el[$], ez[$];
    int hd[0:3], hw[0:3];
    int got, nlast, dcyc, cyc, iy, ix, dd;
    for (int oy = 0; oy < v.os; oy++)
      for (int ox = 0; ox < v.os; ox++)
        for (int ky = 0; ky < v.k; ky++)
          for (int kx = 0; kx < v.k; kx++)
            for (int c = 0; c < v.c; c++) begin
              iy = oy * v.s + ky - v.p;
              ix = ox * v.s + kx - v.p;
              if (iy < 0 || ix < 0 || iy >= v.is
                  || ix >= v.is) begin
                dd = v.db;
                ez.push_back(1);
              end else begin
                dd = v.db + (iy * v.is + ix) * v.c + c;
                ez.push_back(0);
              end
              ed.push_back(dd & 8191);
              ew.push_back((v.wb + (ky * v.k + kx) * v.c + c)
                           & 8191);
              ef.push_back(c == 0 && kx == 0 && ky == 0);
              el.push_back(c == v.c - 1 && kx == v.k - 1
                           && ky == v.k - 1);
            end
    cap_d.delete();
    cap_w.delete();
    cap_z.delete();
    for (int j = 0; j < 4; j++) begin
      hd[j] = 0;
      hw[j] = 0;
    end
    @(negedge clk);
    kernel    = 8'(v.k);
    stride    = 4'(v.s);
    i_side    = 8'(v.is);
    o_side    = 8'(v.os);
    i_channel = 16'(v.c);
    d_base    = AW'(v.db);
    w_base    = AW'(v.wb);
    pad       = 4'(v.p);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    kernel    = 8'hff;
    i_channel = 16'h7;
    d_base    = AW'(1234);
    chk("busy_first", int'(busy), int'(v.exp_n > 0));
    got = 0;
    nlast = 0;
    dcyc = -1;
    cyc = 1;
    while (dcyc < 0 && cyc < 3000) begin
      for (int j = LAT; j > 0; j--) begin
        hd[j] = hd[j-1];
        hw[j] = hw[j-1];
      end
      hd[0] = int'(d_addr);
      hw[0] = int'(w_addr);
      if (rd_valid) begin
        if (got < ed.size()) begin
          chk($sformatf("d_addr[%0d]", got), hd[LAT], ed[got]);
          chk($sformatf("w_addr[%0d]", got), hw[LAT], ew[got]);
          chk($sformatf("first[%0d]", got),
              int'(win_first), ef[got]);
          chk($sformatf("last[%0d]", got),
              int'(win_last), el[got]);
`ifdef GEMM_PAD_EN
          chk($sformatf("pad_zero[%0d]", got),
              int'(pad_zero), ez[got]);
`endif
        end else begin
          chk("extra_rd_valid", got, ed.size() - 1);
        end
        cap_d.push_back(hd[LAT]);
        cap_w.push_back(hw[LAT]);
        cap_z.push_back(int'(pad_zero));
        if (win_last) nlast++;
        got++;
      end
      if (done) dcyc = cyc;
      stall = (cyc >= v.st_at && cyc < v.st_at + v.st_len);
      @(negedge clk);
      cyc++;
    end
    stall = 1'b0;
    if (dcyc < 0) chk("done_timeout", 0, 1);
    chk("done_pulse", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    chk("n_valid", got, v.exp_n);
    chk("done_cycle", dcyc, v.exp_done);
    chk("n_win_last", nlast, v.exp_last);
    if (v.exp_n > 0 && cap_d.size() > 0)
      chk("first_d_addr", cap_d[0], v.exp_d0);
  endtask

  initial begin
    int pz[9];
    int wr[4];
    int cnt;
    pz = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    wr = '{8190, 8191, 0, 1};
    vt[0] = '{1, 1, 2, 2, 1, 0, 0, 0, 0, 0, 4, 6, 4, 0};
    vt[1] = '{3, 2, 5, 2, 2, 0, 0, 0, 0, 0, 72, 74, 4, 0};
    vt[2] = '{3, 2, 5, 2, 2, 0, 0, 0, 20, 5, 72, 79, 4, 0};
    vt[3] = '{1, 1, 1, 1, 4, 8190, 0, 0, 0, 0, 4, 6, 1, 8190};
    vt[4] = '{3, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[5] = '{0, 1, 4, 2, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vt[6] = '{2, 1, 3, 2, 3, 100, 50, 0, 0, 0, 48, 50, 4, 100};
    vt[7] = '{3, 1, 2, 2, 1, 0, 0, 1, 0, 0, 36, 38, 4, 0};
`ifdef GEMM_PAD_EN
    n_vec = 8;
`else
    n_vec = 7;
`endif

    repeat (3) @(negedge clk);
    chk("rst_d_addr", int'(d_addr), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_flags", int'({win_first, win_last, pad_zero}), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < n_vec; i++) begin
      run_vec(vt[i]);
      if (i == 1 && cap_d.size() >= 36) begin
        for (int j = 0; j < 18; j++) begin
          chk($sformatf("win0_d[%0d]", j), cap_d[j],
              (j / 6) * 10 + j % 6);
          chk($sformatf("win1_w[%0d]", j), cap_w[18 + j], j);
        end
        chk("win1_d_start", cap_d[18], 4);
      end
      if (i == 3 && cap_d.size() >= 4)
        for (int j = 0; j < 4; j++)
          chk($sformatf("wrap_d[%0d]", j), cap_d[j], wr[j]);
      if (i == 7 && cap_z.size() >= 9) begin
        for (int j = 0; j < 9; j++)
          chk($sformatf("pad_pat[%0d]", j), cap_z[j], pz[j]);
        chk("pad_d4", cap_d[4], 0);
        chk("pad_d5", cap_d[5], 1);
        chk("pad_d7", cap_d[7], 2);
        chk("pad_d8", cap_d[8], 3);
      end
    end

    @(negedge clk);
    kernel    = 8'd3;
    stride    = 4'd2;
    i_side    = 8'd5;
    o_side    = 8'd2;
    i_channel = 16'd2;
    d_base    = AW'(300);
    w_base    = AW'(0);
    pad       = 4'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 10; c++) begin
      if (rd_valid) cnt++;
      if (cnt < 10) @(negedge clk);
    end
    chk("reached_op10", cnt, 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd_valid", int'(rd_valid), 0);
    chk("mid_rst_flags", int'({win_first, win_last}), 0);
    chk("mid_rst_busy_done", int'({busy, done}), 0);
    chk("mid_rst_addrs", int'(d_addr) + int'(w_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_valid", int'(rd_valid), 0);
    run_vec(vt[6]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
